ws_line_ram: RTL and testbench

On-chip Wishbone responder that serves the cache's 512-bit line port (addr/din/dout/dm/cyc/stb/we/ack) from block RAM. It stands in for the DDR2 wrapper on boards or builds without external DRAM, and as a bench model for the cache. It presents the same line-wide handshake with a programmable access latency, so the cache-side controller is exercised unchanged.

---
 rtl/ws_line_ram.sv | 120 ++++++++++++
 tb/tb_ws_line_ram.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ws_line_ram.sv
// ws_line_ram: block-RAM Wishbone responder for 512-bit cache lines.
// It replaces the DRAM wrapper and acks each request after a programmable latency.
module ws_line_ram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  ws_addr,
  input  logic [511:0] ws_din,
  input  logic [63:0]  ws_dm,
  input  logic         ws_cyc,
  input  logic         ws_stb,
  input  logic         ws_we,
  output logic [511:0] ws_dout,
  output logic         ws_ack,
  output logic [2:0]   dbg_state
);

  localparam int unsigned LINE_W = 512;
  localparam int unsigned BYTES  = 64;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BUSY = 3'd1,
    ST_ACK  = 3'd2,
    ST_HOLD = 3'd3
  } state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic                    we_q;
  logic [LINE_W-1:0]       din_q;
  logic [BYTES-1:0]        dm_q;
  logic                    capture_c;
  logic                    rd_fire_c;
  logic                    ack_c;
  logic                    addr_unused;

  logic [LINE_W-1:0]       mem [DEPTH];

  // Offset and high address bits alias onto the same line.
  assign addr_unused = ^{ws_addr[31:ADDR_WIDTH+6], ws_addr[5:0]};

  // Next-state, counter and strobe decode.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    capture_c = 1'b0;
    rd_fire_c = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ws_cyc && ws_stb) begin
          capture_c = 1'b1;
          cnt_n     = CNT_W'(LATENCY - 1);
          state_n   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!ws_cyc) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else if (cnt == '0) begin
          rd_fire_c = !we_q;
          state_n   = ST_ACK;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_ACK:  state_n = ST_HOLD;
      ST_HOLD: begin
        if (!ws_stb) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    ack_c = (state_n == ST_ACK);
  end

  // State, request capture and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      din_q     <= '0;
      dm_q      <= '0;
      ws_ack    <= 1'b0;
      ws_dout   <= '0;
      dbg_state <= 3'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ws_ack    <= ack_c;
      dbg_state <= state_n;
      if (capture_c) begin
        idx_q <= ws_addr[ADDR_WIDTH+5:6];
        we_q  <= ws_we;
        din_q <= ws_din;
        dm_q  <= ws_dm;
      end
      if (rd_fire_c) begin
        ws_dout <= mem[idx_q];
      end
    end
  end

  // Byte-masked line write, committed at the end of the ack cycle.
  always_ff @(posedge clk) begin
    if (state == ST_ACK && we_q) begin
      for (int b = 0; b < BYTES; b++) begin
        if (dm_q[b]) mem[idx_q][8*b +: 8] <= din_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ws_line_ram.sv
// tb_ws_line_ram: directed bench with a transaction-level model of the line RAM.
module tb_ws_line_ram;

  localparam int unsigned LAT = 4;

  logic         clk;
  logic         rst;
  logic [31:0]  addr;
  logic [511:0] din;
  logic [63:0]  dm;
  logic         cyc;
  logic         stb;
  logic         we;
  logic [511:0] ws_dout;
  logic         ws_ack;
  logic [2:0]   dbg_state;

  int n_chk = 0;
  int n_bad = 0;
  int cycle = 0;
  int req_cycle = 0;
  int ack_cnt = 0;

  // Model: phase numbers follow the visible state encoding.
  int           m_phase = 0;
  int           m_due   = 0;
  logic [9:0]   m_idx;
  logic         m_we;
  logic [511:0] m_din;
  logic [63:0]  m_dm;
  logic [511:0] m_dout  = '0;
  bit           m_known = 1'b1;
  logic [511:0] mmem [1024];
  bit           mvalid [1024];

  ws_line_ram #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .ws_addr(addr), .ws_din(din), .ws_dm(dm),
    .ws_cyc(cyc), .ws_stb(stb), .ws_we(we), .ws_dout(ws_dout),
    .ws_ack(ws_ack), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  function automatic logic [511:0] fill(input logic [7:0] v);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[8*i +: 8] = v;
    return r;
  endfunction

  function automatic logic [511:0] pat_inc();
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[8*i +: 8] = 8'(i * 17);
    return r;
  endfunction

  function automatic logic [511:0] pat_alias();
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[8*i +: 8] = 8'(i) ^ 8'hC0;
    return r;
  endfunction

  // Model update on rising edges, comparison on falling edges.
  initial begin : model_cmp
    for (int i = 0; i < 1024; i++) mvalid[i] = 1'b0;
    forever begin
      @(clk);
      if (clk) begin
        cycle++;
        if (!rst) begin
          case (m_phase)
            0: if (cyc && stb) begin
                 m_idx = addr[15:6]; m_we = we; m_din = din; m_dm = dm;
                 m_due = cycle + LAT; m_phase = 1;
               end
            1: if (!cyc) m_phase = 0;
               else if (cycle == m_due) begin
                 m_phase = 2;
                 if (!m_we) begin m_dout = mmem[m_idx]; m_known = mvalid[m_idx]; end
               end
            2: begin
                 m_phase = 3;
                 if (m_we) begin
                   for (int b = 0; b < 64; b++)
                     if (m_dm[b]) mmem[m_idx][8*b +: 8] = m_din[8*b +: 8];
                   if (m_dm == '1) mvalid[m_idx] = 1'b1;
                 end
               end
            default: if (!stb) m_phase = 0;
          endcase
        end
      end else begin
        if (rst) begin m_phase = 0; m_dout = '0; m_known = 1'b1; end
        check("ack", 512'(ws_ack), 512'(m_phase == 2));
        check("state", 512'(dbg_state), 512'(m_phase));
        if (m_known) check("dout", ws_dout, m_dout);
        if (ws_ack === 1'b1) ack_cnt++;
      end
    end
  end

  task automatic start(input logic [31:0] a, input logic w, input logic [511:0] d, input logic [63:0] m);
    @(posedge clk); #1;
    addr = a; we = w; din = d; dm = m; cyc = 1'b1; stb = 1'b1;
    req_cycle = cycle + 1;
  endtask

  task automatic wait_ack(output logic [511:0] rd, output int lat);
    int n = 0;
    bit got = 1'b0;
    rd = '0;
    while (!got && n < 40) begin
      @(negedge clk); n++;
      if (ws_ack === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_chk++; n_bad++;
      $display("FAIL ack_timeout act=no_ack exp=ack (cycle %0d)", cycle);
    end
    rd = ws_dout;
    lat = cycle - req_cycle;
  endtask

  task automatic release_bus();
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [511:0] d,
                      input logic [63:0] m, output logic [511:0] rd);
    int lat;
    start(a, w, d, m);
    wait_ack(rd, lat);
    check("latency", 512'(lat), 512'(4));
    release_bus();
  endtask

  logic [511:0] rd;
  int acks_before;
  int lat;

  initial begin
    rst = 1'b1; addr = '0; din = '0; dm = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ack", 512'(ws_ack), 512'(0));
    check("rst_dout", ws_dout, 512'(0));
    check("rst_state", 512'(dbg_state), 512'(0));

    // Full-line write then read back.
    xfer(32'h0000_0040, 1'b1, pat_inc(), '1, rd);
    xfer(32'h0000_0040, 1'b0, '0, '0, rd);
    check("full_line", rd, pat_inc());
    check("full_b1", 512'(rd[15:8]), 512'(8'h11));
    check("full_b63", 512'(rd[511:504]), 512'(8'h2F));

    // Partial write of bytes 0..7 over a 0x55 line.
    xfer(32'h0000_0080, 1'b1, fill(8'h55), '1, rd);
    xfer(32'h0000_0080, 1'b1, fill(8'hAA), 64'h0000_0000_0000_00FF, rd);
    xfer(32'h0000_0080, 0, '0, '0, rd);
    check("part_lo", 512'(rd[63:0]), 512'(64'hAAAA_AAAA_AAAA_AAAA));
    check("part_b8", 512'(rd[71:64]), 512'(8'h55));
    check("part_b63", 512'(rd[511:504]), 512'(8'h55));

    // Aliasing: high bits and line offset are ignored.
    xfer(32'h0001_0000, 1'b1, pat_alias(), '1, rd);
    xfer(32'h0000_003F, 1'b0, '0, '0, rd);
    check("alias_line", rd, pat_alias());
    check("alias_b0", 512'(rd[7:0]), 512'(8'hC0));

    // Strobe held across ack: one ack, HOLD until strobe drops.
    acks_before = ack_cnt;
    start(32'h0000_0040, 1'b0, '0, '0);
    wait_ack(rd, lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_state", 512'(dbg_state), 512'(3));
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("hold_idle", 512'(dbg_state), 512'(0));
    check("hold_one_ack", 512'(ack_cnt - acks_before), 512'(1));
    xfer(32'h0000_0040, 1'b0, '0, '0, rd);
    check("hold_new_req", rd, pat_inc());

    // Abort during BUSY: no ack, no write.
    acks_before = ack_cnt;
    start(32'h0000_0040, 1'b1, fill(8'hFF), '1);
    @(posedge clk);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_idle", 512'(dbg_state), 512'(0));
    repeat (6) @(negedge clk);
    check("abort_no_ack", 512'(ack_cnt - acks_before), 512'(0));
    xfer(32'h0000_0040, 1'b0, '0, '0, rd);
    check("abort_mem", rd, pat_inc());

    // Reset during BUSY of a write.
    start(32'h0000_0080, 1'b1, fill(8'h00), '1);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid_ack", 512'(ws_ack), 512'(0));
    check("rst_mid_dout", ws_dout, 512'(0));
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (2) @(posedge clk);
    xfer(32'h0000_0080, 1'b0, '0, '0, rd);
    check("rst_mem_lo", 512'(rd[63:0]), 512'(64'hAAAA_AAAA_AAAA_AAAA));
    check("rst_mem_hi", 512'(rd[511:504]), 512'(8'h55));

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
